output_uart_verilog: RTL

Downstream sink for the processor's `data_output` value. Buffers each strobed 16-bit result in a small FIFO and serialises it on a UART TX line as four uppercase ASCII hex digits followed by a line feed (`"1A2F\n"`). Integration drives `data_valid` for one cycle whenever an output-class instruction presents a value on `data_output`.

---
 rtl/output_uart_verilog.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/output_uart_verilog.sv
// Output sink: buffers strobed 16-bit words in a FIFO and sends each one on a
// UART TX line as four uppercase hex digits followed by a line feed.
//
// state | meaning
// IDLE  | line idle, waiting for a queued word
// START | start bit, tx low for one bit period
// DATA  | eight data bits of the current character, LSB first
// STOP  | stop bit; chains into the next character or the next word
module output_uart_verilog #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  tx,
  output logic                  busy,
  output logic                  fifo_full,
  output logic [7:0]            dropped_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_CHAR = 3'd4;
  localparam logic [2:0]        LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [BAUD_W-1:0]     baud_cnt, baud_n;
  logic [2:0]            bit_idx, bit_n;
  logic [2:0]            char_idx, char_n;
  logic [DATA_WIDTH-1:0] word_reg, word_n;
  logic [7:0]            cur_char;
  logic                  tx_n;
  logic                  pop, push, drop;
  logic                  fifo_empty, baud_done;

  // Character idx of the word: 0..3 are hex digits MSB first, 4 is line feed.
  function automatic logic [7:0] char_byte(input logic [15:0] w, input logic [2:0] idx);
    logic [3:0] nib;
    logic [7:0] res;
    nib = 4'h0;
    case (idx)
      3'd0:    nib = w[15:12];
      3'd1:    nib = w[11:8];
      3'd2:    nib = w[7:4];
      3'd3:    nib = w[3:0];
      default: nib = 4'h0;
    endcase
    if (idx >= LAST_CHAR) res = 8'h0A;
    else if (nib < 4'd10) res = {4'h3, nib};
    else                  res = 8'h37 + {4'h0, nib};
    return res;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign busy       = (state != S_IDLE);

  // A pop frees a slot in the same edge, so a push into a full FIFO is kept.
  assign push = data_valid && (!fifo_full || pop);
  assign drop = data_valid && fifo_full && !pop;

  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    char_n  = char_idx;
    word_n  = word_reg;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_n  = mem[rd_ptr];
          char_n  = 3'd0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          bit_n   = 3'd0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          if (bit_idx == LAST_BIT) state_n = S_STOP;
          else                     bit_n   = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (char_idx < LAST_CHAR) begin
            char_n  = char_idx + 3'd1;
            state_n = S_START;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            word_n  = mem[rd_ptr];
            char_n  = 3'd0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (state == S_IDLE || baud_done || state_n != state) baud_n = '0;
    else                                                  baud_n = baud_cnt + BAUD_W'(1);

    // tx is registered, so it is derived from where the FSM is heading.
    cur_char = char_byte(word_n, char_n);
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = cur_char[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      word_reg <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      char_idx <= char_n;
      word_reg <= word_n;
      tx       <= tx_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      dropped_count <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop && dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule
